// File: rtl/rf_writeback_queue_if.sv
// Bus bundle for the register-file writeback queue: two producer handshakes
// (load/mem and ALU), the regfile write port, and the decode source queries.
// The "slave" modport is the queue itself; "master" is everything around it.
interface rf_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // load/mem producer
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    // ALU producer
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    // regfile write port
    logic              RegWrite;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;

    // decode hazard / bypass queries
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              busy1;
    logic              busy2;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;

    // occupancy
    logic [CNT_W-1:0]  count;

    modport master (
        output mem_valid, mem_rd, mem_data,
        output alu_valid, alu_rd, alu_data,
        output rs1, rs2,
        input  mem_ready, alu_ready,
        input  RegWrite, wr, wd,
        input  busy1, busy2, fwd1, fwd2,
        input  count
    );

    modport slave (
        input  mem_valid, mem_rd, mem_data,
        input  alu_valid, alu_rd, alu_data,
        input  rs1, rs2,
        output mem_ready, alu_ready,
        output RegWrite, wr, wd,
        output busy1, busy2, fwd1, fwd2,
        output count
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the 32x32 register file. Results from the
// load/mem unit and the ALU are accepted through valid/ready, kept in program
// order in a small circular FIFO, and one entry is written to the regfile per
// clock. Decode can ask whether a source register still has a write in flight
// and obtain the youngest queued value for bypassing.
module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    rf_writeback_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage and bookkeeping
    logic [ADDR_W-1:0] rd_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // handshake / update terms
    logic [CNT_W-1:0]  free_s;
    logic              mem_ready_s;
    logic              alu_ready_s;
    logic              mem_enq_s;
    logic              alu_enq_s;
    logic              deq_s;
    logic [CNT_W-1:0]  enq_n_s;
    logic [PTR_W-1:0]  alu_slot_s;
    logic [CNT_W-1:0]  count_nxt_s;

    // write-port and lookup results
    logic [ADDR_W-1:0] wr_s;
    logic [DATA_W-1:0] wd_s;
    logic              busy1_s;
    logic              busy2_s;
    logic [DATA_W-1:0] fwd1_s;
    logic [DATA_W-1:0] fwd2_s;

    // Admission control and enqueue/dequeue bookkeeping. Free space is taken
    // from the registered count only: the pop happening at the same edge is not
    // credited, so count can never go past DEPTH. When both producers present,
    // the ALU needs room for two so the mem result (older) always fits first.
    // Writes to x0 complete their handshake but never occupy a slot.
    always_comb begin
        free_s      = CNT_W'(DEPTH) - count_r;
        mem_ready_s = (free_s >= CNT_W'(1));
        if (bus.mem_valid) begin
            alu_ready_s = (free_s >= CNT_W'(2));
        end else begin
            alu_ready_s = (free_s >= CNT_W'(1));
        end
        mem_enq_s   = bus.mem_valid && mem_ready_s && (bus.mem_rd != {ADDR_W{1'b0}});
        alu_enq_s   = bus.alu_valid && alu_ready_s && (bus.alu_rd != {ADDR_W{1'b0}});
        deq_s       = (count_r != {CNT_W{1'b0}});
        enq_n_s     = CNT_W'(mem_enq_s) + CNT_W'(alu_enq_s);
        alu_slot_s  = wr_ptr_r + PTR_W'(mem_enq_s);
        count_nxt_s = count_r + enq_n_s - CNT_W'(deq_s);
    end

    // FIFO state: reset clears everything and wins over any same-cycle traffic;
    // otherwise store accepted entries (mem before ALU) and retire the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= {ADDR_W{1'b0}};
                data_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (mem_enq_s) begin
                rd_mem_r[wr_ptr_r]   <= bus.mem_rd;
                data_mem_r[wr_ptr_r] <= bus.mem_data;
            end else begin
                rd_mem_r[wr_ptr_r]   <= rd_mem_r[wr_ptr_r];
                data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
            end
            if (alu_enq_s) begin
                rd_mem_r[alu_slot_s]   <= bus.alu_rd;
                data_mem_r[alu_slot_s] <= bus.alu_data;
            end else begin
                rd_mem_r[alu_slot_s]   <= rd_mem_r[alu_slot_s];
                data_mem_r[alu_slot_s] <= data_mem_r[alu_slot_s];
            end
            rd_ptr_r <= rd_ptr_r + PTR_W'(deq_s);
            wr_ptr_r <= wr_ptr_r + PTR_W'(enq_n_s);
            count_r  <= count_nxt_s;
        end
    end

    // Regfile write port: head entry straight from storage, forced to zero when
    // the queue is empty so an idle port never shows stale data.
    always_comb begin
        wr_s = {ADDR_W{1'b0}};
        wd_s = {DATA_W{1'b0}};
        if (deq_s) begin
            wr_s = rd_mem_r[rd_ptr_r];
            wd_s = data_mem_r[rd_ptr_r];
        end else begin
            wr_s = {ADDR_W{1'b0}};
            wd_s = {DATA_W{1'b0}};
        end
    end

    // Decode lookup over occupied entries only, walking oldest to youngest so
    // the last hit (youngest value) is what gets forwarded. x0 never matches.
    always_comb begin : fwd_lookup
        logic [PTR_W-1:0] idx;
        idx     = rd_ptr_r;
        busy1_s = 1'b0;
        busy2_s = 1'b0;
        fwd1_s  = {DATA_W{1'b0}};
        fwd2_s  = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_r + PTR_W'(i);
            if (CNT_W'(i) < count_r) begin
                if ((bus.rs1 != {ADDR_W{1'b0}}) && (rd_mem_r[idx] == bus.rs1)) begin
                    busy1_s = 1'b1;
                    fwd1_s  = data_mem_r[idx];
                end else begin
                    busy1_s = busy1_s;
                    fwd1_s  = fwd1_s;
                end
                if ((bus.rs2 != {ADDR_W{1'b0}}) && (rd_mem_r[idx] == bus.rs2)) begin
                    busy2_s = 1'b1;
                    fwd2_s  = data_mem_r[idx];
                end else begin
                    busy2_s = busy2_s;
                    fwd2_s  = fwd2_s;
                end
            end else begin
                busy1_s = busy1_s;
                busy2_s = busy2_s;
                fwd1_s  = fwd1_s;
                fwd2_s  = fwd2_s;
            end
        end
    end

    assign bus.mem_ready = mem_ready_s;
    assign bus.alu_ready = alu_ready_s;
    assign bus.RegWrite  = deq_s;
    assign bus.wr        = wr_s;
    assign bus.wd        = wd_s;
    assign bus.busy1     = busy1_s;
    assign bus.busy2     = busy2_s;
    assign bus.fwd1      = fwd1_s;
    assign bus.fwd2      = fwd2_s;
    assign bus.count     = count_r;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: a DEPTH=4 instance for reset, basic
// drain, ordering, x0 and random traffic, and a DEPTH=2 instance to reach the
// full condition (with one pop per clock a 4-deep queue tops out at 3).
module tb_rf_writeback_queue;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rf_writeback_queue_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) b4 ();
    rf_writeback_queue_if #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) b2 ();

    rf_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    rf_writeback_queue #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    // occupancy must never exceed the queue depth
    always @(negedge clk) begin
        if (!rst) begin
            assert (b4.count <= 3'd4) else $error("count4 overflow %0d", b4.count);
            assert (b2.count <= 2'd2) else $error("count2 overflow %0d", b2.count);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        b4.mem_valid = 1'b0; b4.mem_rd = 5'd0; b4.mem_data = 32'd0;
        b4.alu_valid = 1'b0; b4.alu_rd = 5'd0; b4.alu_data = 32'd0;
    endtask

    task automatic idle2();
        b2.mem_valid = 1'b0; b2.mem_rd = 5'd0; b2.mem_data = 32'd0;
        b2.alu_valid = 1'b0; b2.alu_rd = 5'd0; b2.alu_data = 32'd0;
    endtask

    function automatic logic [4:0] pick_rd();
        return 5'($urandom_range(0, 7));
    endfunction

    ent_t mq[$];
    int   free_m;
    logic exp_mr, exp_ar, m_acc, a_acc;
    logic exp_b1, exp_b2;
    logic [31:0] exp_f1, exp_f2;

    initial begin
        rst = 1'b1;
        idle4(); idle2();
        b4.rs1 = 5'd0; b4.rs2 = 5'd0; b2.rs1 = 5'd0; b2.rs2 = 5'd0;
        repeat (2) tick();
        rst = 1'b0;

        // 1: reset while writes are pending
        b4.mem_valid = 1'b1; b4.mem_rd = 5'd5; b4.mem_data = 32'h55;
        b4.alu_valid = 1'b1; b4.alu_rd = 5'd6; b4.alu_data = 32'h66;
        tick();
        idle4(); rst = 1'b1; b4.rs1 = 5'd5;
        @(negedge clk);
        chk("t1_pend_rw", 64'(b4.RegWrite), 64'd1);
        chk("t1_pend_cnt", 64'(b4.count), 64'd2);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t1_rw", 64'(b4.RegWrite), 64'd0);
        chk("t1_cnt", 64'(b4.count), 64'd0);
        chk("t1_mrdy", 64'(b4.mem_ready), 64'd1);
        chk("t1_ardy", 64'(b4.alu_ready), 64'd1);
        chk("t1_wr", 64'(b4.wr), 64'd0);
        chk("t1_wd", 64'(b4.wd), 64'd0);
        chk("t1_busy", 64'(b4.busy1), 64'd0);

        // 2: single ALU result, one-cycle latency then drained
        tick();
        b4.alu_valid = 1'b1; b4.alu_rd = 5'd3; b4.alu_data = 32'h11; b4.rs1 = 5'd3;
        @(negedge clk);
        chk("t2_ardy", 64'(b4.alu_ready), 64'd1);
        chk("t2_nobypass", 64'(b4.busy1), 64'd0);
        tick(); idle4();
        @(negedge clk);
        chk("t2_rw", 64'(b4.RegWrite), 64'd1);
        chk("t2_wr", 64'(b4.wr), 64'd3);
        chk("t2_wd", 64'(b4.wd), 64'h11);
        chk("t2_cnt", 64'(b4.count), 64'd1);
        chk("t2_busy", 64'(b4.busy1), 64'd1);
        chk("t2_fwd", 64'(b4.fwd1), 64'h11);
        tick();
        @(negedge clk);
        chk("t2_cnt0", 64'(b4.count), 64'd0);
        chk("t2_rw0", 64'(b4.RegWrite), 64'd0);
        chk("t2_fwd0", 64'(b4.fwd1), 64'd0);

        // 3: simultaneous mem/ALU to same rd, mem is older, youngest forwards
        tick();
        b4.mem_valid = 1'b1; b4.mem_rd = 5'd7; b4.mem_data = 32'hAA;
        b4.alu_valid = 1'b1; b4.alu_rd = 5'd7; b4.alu_data = 32'hBB; b4.rs1 = 5'd7;
        @(negedge clk);
        chk("t3_mrdy", 64'(b4.mem_ready), 64'd1);
        chk("t3_ardy", 64'(b4.alu_ready), 64'd1);
        tick(); idle4();
        @(negedge clk);
        chk("t3_cnt2", 64'(b4.count), 64'd2);
        chk("t3_wr_a", 64'(b4.wr), 64'd7);
        chk("t3_wd_a", 64'(b4.wd), 64'hAA);
        chk("t3_busy", 64'(b4.busy1), 64'd1);
        chk("t3_fwd_y", 64'(b4.fwd1), 64'hBB);
        tick();
        @(negedge clk);
        chk("t3_cnt1", 64'(b4.count), 64'd1);
        chk("t3_wd_b", 64'(b4.wd), 64'hBB);
        chk("t3_fwd_b", 64'(b4.fwd1), 64'hBB);
        tick();
        @(negedge clk);
        chk("t3_busy0", 64'(b4.busy1), 64'd0);

        // 4: peak occupancy on the 4-deep queue, ALU held off by mem
        tick();
        b4.mem_valid = 1'b1; b4.mem_rd = 5'd1; b4.mem_data = 32'h101;
        b4.alu_valid = 1'b1; b4.alu_rd = 5'd2; b4.alu_data = 32'h202;
        tick();
        b4.mem_rd = 5'd8; b4.mem_data = 32'h808; b4.alu_rd = 5'd9; b4.alu_data = 32'h909;
        @(negedge clk);
        chk("t4_cnt2", 64'(b4.count), 64'd2);
        chk("t4_wr1", 64'(b4.wr), 64'd1);
        chk("t4_ardy2", 64'(b4.alu_ready), 64'd1);
        tick();
        b4.mem_rd = 5'd10; b4.mem_data = 32'hA0A; b4.alu_rd = 5'd11; b4.alu_data = 32'hB0B;
        b4.rs1 = 5'd9; b4.rs2 = 5'd8;
        @(negedge clk);
        chk("t4_cnt3", 64'(b4.count), 64'd3);
        chk("t4_wr2", 64'(b4.wr), 64'd2);
        chk("t4_mrdy3", 64'(b4.mem_ready), 64'd1);
        chk("t4_ardy3", 64'(b4.alu_ready), 64'd0);
        chk("t4_fwd1", 64'(b4.fwd1), 64'h909);
        chk("t4_fwd2", 64'(b4.fwd2), 64'h808);
        tick();
        b4.mem_valid = 1'b0;
        @(negedge clk);
        chk("t4_cnt3b", 64'(b4.count), 64'd3);
        chk("t4_wr8", 64'(b4.wr), 64'd8);
        chk("t4_ardy_nomem", 64'(b4.alu_ready), 64'd1);
        tick();
        b4.alu_valid = 1'b0;
        @(negedge clk);
        chk("t4_wr9", 64'(b4.wr), 64'd9);
        chk("t4_wd9", 64'(b4.wd), 64'h909);
        tick();
        @(negedge clk);
        chk("t4_wr10", 64'(b4.wr), 64'd10);
        tick();
        @(negedge clk);
        chk("t4_wd11", 64'(b4.wd), 64'hB0B);
        chk("t4_cnt1", 64'(b4.count), 64'd1);
        tick();
        @(negedge clk);
        chk("t4_cnt0", 64'(b4.count), 64'd0);

        // 4b: full condition on the 2-deep queue
        tick();
        b2.mem_valid = 1'b1; b2.mem_rd = 5'd4; b2.mem_data = 32'h44;
        b2.alu_valid = 1'b1; b2.alu_rd = 5'd5; b2.alu_data = 32'h55;
        tick();
        b2.mem_rd = 5'd6; b2.mem_data = 32'h66; b2.alu_valid = 1'b0;
        @(negedge clk);
        chk("t4f_cnt", 64'(b2.count), 64'd2);
        chk("t4f_mrdy", 64'(b2.mem_ready), 64'd0);
        chk("t4f_ardy", 64'(b2.alu_ready), 64'd0);
        chk("t4f_wr", 64'(b2.wr), 64'd4);
        tick();
        @(negedge clk);
        chk("t4f_cnt1", 64'(b2.count), 64'd1);
        chk("t4f_mrdy1", 64'(b2.mem_ready), 64'd1);
        chk("t4f_ardy1", 64'(b2.alu_ready), 64'd0);
        chk("t4f_wr5", 64'(b2.wr), 64'd5);
        tick();
        b2.mem_valid = 1'b0;
        @(negedge clk);
        chk("t4f_wd6", 64'(b2.wd), 64'h66);
        tick();
        @(negedge clk);
        chk("t4f_cnt0", 64'(b2.count), 64'd0);

        // 5: writes to x0 are accepted but never queued
        tick();
        b4.alu_valid = 1'b1; b4.alu_rd = 5'd0; b4.alu_data = 32'hFF;
        @(negedge clk);
        chk("t5_ardy", 64'(b4.alu_ready), 64'd1);
        tick(); idle4();
        @(negedge clk);
        chk("t5_cnt", 64'(b4.count), 64'd0);
        chk("t5_rw", 64'(b4.RegWrite), 64'd0);
        tick();
        b4.mem_valid = 1'b1; b4.mem_rd = 5'd0; b4.mem_data = 32'hEE;
        b4.alu_valid = 1'b1; b4.alu_rd = 5'd12; b4.alu_data = 32'hCC;
        tick(); idle4();
        @(negedge clk);
        chk("t5_cnt1", 64'(b4.count), 64'd1);
        chk("t5_wr12", 64'(b4.wr), 64'd12);
        chk("t5_wdcc", 64'(b4.wd), 64'hCC);
        tick();

        // 6: random traffic against an in-order scoreboard
        mq.delete();
        for (int c = 0; c < 1000; c++) begin
            if (!b4.mem_valid) begin
                b4.mem_valid = ($urandom_range(0, 3) != 0);
                b4.mem_rd    = pick_rd();
                b4.mem_data  = $urandom;
            end
            if (!b4.alu_valid) begin
                b4.alu_valid = ($urandom_range(0, 3) != 0);
                b4.alu_rd    = pick_rd();
                b4.alu_data  = $urandom;
            end
            b4.rs1 = pick_rd();
            b4.rs2 = pick_rd();
            @(negedge clk);
            free_m = 4 - mq.size();
            exp_mr = (free_m >= 1);
            exp_ar = b4.mem_valid ? (free_m >= 2) : (free_m >= 1);
            exp_b1 = 1'b0; exp_b2 = 1'b0; exp_f1 = 32'd0; exp_f2 = 32'd0;
            foreach (mq[k]) begin
                if (b4.rs1 != 5'd0 && mq[k].rd == b4.rs1) begin exp_b1 = 1'b1; exp_f1 = mq[k].d; end
                if (b4.rs2 != 5'd0 && mq[k].rd == b4.rs2) begin exp_b2 = 1'b1; exp_f2 = mq[k].d; end
            end
            chk("t6_mrdy", 64'(b4.mem_ready), 64'(exp_mr));
            chk("t6_ardy", 64'(b4.alu_ready), 64'(exp_ar));
            chk("t6_cnt", 64'(b4.count), 64'(mq.size()));
            chk("t6_rw", 64'(b4.RegWrite), 64'(mq.size() != 0));
            chk("t6_wr", 64'(b4.wr), (mq.size() != 0) ? 64'(mq[0].rd) : 64'd0);
            chk("t6_wd", 64'(b4.wd), (mq.size() != 0) ? 64'(mq[0].d) : 64'd0);
            chk("t6_busy1", 64'(b4.busy1), 64'(exp_b1));
            chk("t6_busy2", 64'(b4.busy2), 64'(exp_b2));
            chk("t6_fwd1", 64'(b4.fwd1), 64'(exp_f1));
            chk("t6_fwd2", 64'(b4.fwd2), 64'(exp_f2));
            m_acc = b4.mem_valid && exp_mr;
            a_acc = b4.alu_valid && exp_ar;
            tick();
            if (mq.size() != 0) void'(mq.pop_front());
            if (m_acc) begin
                if (b4.mem_rd != 5'd0) mq.push_back('{rd: b4.mem_rd, d: b4.mem_data});
                b4.mem_valid = 1'b0;
            end
            if (a_acc) begin
                if (b4.alu_rd != 5'd0) mq.push_back('{rd: b4.alu_rd, d: b4.alu_data});
                b4.alu_valid = 1'b0;
            end
        end
        idle4();
        repeat (5) tick();
        @(negedge clk);
        chk("t6_drained", 64'(b4.count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
